// File: rtl/exe_stage.sv
// Execute stage of the 5-stage LoongArch pipeline: ALU, single-cycle multiply,
// 32-step restoring divider, data SRAM request and forwarding to decode.
module exe_stage #(
  parameter int DS_BUS_W = 155,
  parameter int ES_BUS_W = 71
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [DS_BUS_W-1:0] ds_to_es_bus,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic [ES_BUS_W-1:0] es_to_ms_bus,
  output logic [38:0]         es_rf_collect,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata
);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  logic                es_valid;
  logic                es_ready_go;
  logic [DS_BUS_W-1:0] es_bus;

  logic [18:0] es_op;
  logic        es_res_from_mem;
  logic [31:0] es_src1;
  logic [31:0] es_src2;
  logic        es_mem_we;
  logic        es_rf_we;
  logic [4:0]  es_waddr;
  logic [31:0] es_rkd_value;
  logic [31:0] es_pc;

  assign {es_op, es_res_from_mem, es_src1, es_src2, es_mem_we, es_rf_we,
          es_waddr, es_rkd_value, es_pc} = es_bus;

  // Pipeline handshake and bus latch
  assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_bus <= '0;
    end else if (ds_to_es_valid & es_allowin) begin
      es_bus <= ds_to_es_bus;
    end
  end

  logic op_mul_w, op_mulh_w, op_mulh_wu;
  logic op_div_w, op_mod_w, op_div_wu, op_mod_wu;
  logic is_mul, is_div;

  assign {op_mul_w, op_mulh_w, op_mulh_wu, op_div_w, op_mod_w, op_div_wu, op_mod_wu} = es_op[18:12];
  assign is_mul = op_mul_w | op_mulh_w | op_mulh_wu;
  assign is_div = op_div_w | op_mod_w | op_div_wu | op_mod_wu;

  // ALU: one-hot select via AND-OR so an empty op yields zero
  logic [31:0] alu_add, alu_sub, alu_slt, alu_sltu;
  logic [31:0] alu_sll, alu_srl, alu_sra, alu_result;

  assign alu_add  = es_src1 + es_src2;
  assign alu_sub  = es_src1 - es_src2;
  assign alu_slt  = {31'd0, $signed(es_src1) < $signed(es_src2)};
  assign alu_sltu = {31'd0, es_src1 < es_src2};
  assign alu_sll  = es_src1 << es_src2[4:0];
  assign alu_srl  = es_src1 >> es_src2[4:0];
  assign alu_sra  = $signed(es_src1) >>> es_src2[4:0];

  assign alu_result = ({32{es_op[0]}}  & alu_add)
                    | ({32{es_op[1]}}  & alu_sub)
                    | ({32{es_op[2]}}  & alu_slt)
                    | ({32{es_op[3]}}  & alu_sltu)
                    | ({32{es_op[4]}}  & (es_src1 & es_src2))
                    | ({32{es_op[5]}}  & ~(es_src1 | es_src2))
                    | ({32{es_op[6]}}  & (es_src1 | es_src2))
                    | ({32{es_op[7]}}  & (es_src1 ^ es_src2))
                    | ({32{es_op[8]}}  & alu_sll)
                    | ({32{es_op[9]}}  & alu_srl)
                    | ({32{es_op[10]}} & alu_sra)
                    | ({32{es_op[11]}} & es_src2);

  // 33x33 product; only the low 64 bits matter, so a 64-bit modular multiply
  // of the extended operands is exact
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, mul_prod;
  logic [31:0] mul_result;

  assign mul_signed = op_mul_w | op_mulh_w;
  assign mul_a      = {{32{mul_signed & es_src1[31]}}, es_src1};
  assign mul_b      = {{32{mul_signed & es_src2[31]}}, es_src2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_result = op_mul_w ? mul_prod[31:0] : mul_prod[63:32];

  // Divider operand preparation and sign handling
  logic        div_signed, div_want_rem;
  logic        src1_neg, src2_neg;
  logic [31:0] src1_abs, src2_abs;

  assign div_signed   = op_div_w | op_mod_w;
  assign div_want_rem = op_mod_w | op_mod_wu;
  assign src1_neg     = div_signed & es_src1[31];
  assign src2_neg     = div_signed & es_src2[31];
  assign src1_abs     = src1_neg ? (32'd0 - es_src1) : es_src1;
  assign src2_abs     = src2_neg ? (32'd0 - es_src2) : es_src2;

  div_state_t  div_state, div_state_nxt;
  logic [4:0]  div_cnt;
  logic [31:0] div_rem, div_quo, div_dvs, div_result;
  logic        div_by_zero;
  logic        div_start, div_last;

  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem_nxt, div_quo_nxt, quo_fixed, rem_fixed, div_final;

  // One restoring step: the quotient register doubles as the dividend shifter
  assign div_shift   = {div_rem, div_quo[31]};
  assign div_ge      = div_shift >= {1'b0, div_dvs};
  assign div_rem_nxt = div_ge ? (div_shift[31:0] - div_dvs) : div_shift[31:0];
  assign div_quo_nxt = {div_quo[30:0], div_ge};

  assign quo_fixed = (src1_neg ^ src2_neg) ? (32'd0 - div_quo_nxt) : div_quo_nxt;
  assign rem_fixed = src1_neg ? (32'd0 - div_rem_nxt) : div_rem_nxt;
  assign div_final = div_by_zero ? (div_want_rem ? es_src1 : 32'hFFFF_FFFF)
                                 : (div_want_rem ? rem_fixed : quo_fixed);

  assign div_start = (div_state == DIV_IDLE) & es_valid & is_div;
  assign div_last  = (div_state == DIV_BUSY) & (div_cnt == 5'd31);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_state <= DIV_IDLE;
    end else begin
      div_state <= div_state_nxt;
    end
  end

  always_comb begin
    div_state_nxt = div_state;
    case (div_state)
      DIV_IDLE: if (es_valid & is_div) div_state_nxt = DIV_BUSY;
      DIV_BUSY: if (div_cnt == 5'd31)  div_state_nxt = DIV_DONE;
      DIV_DONE: if (ms_allowin)        div_state_nxt = DIV_IDLE;
      default:                         div_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= 5'd0;
      div_rem     <= 32'd0;
      div_quo     <= 32'd0;
      div_dvs     <= 32'd0;
      div_by_zero <= 1'b0;
      div_result  <= 32'd0;
    end else if (div_start) begin
      div_cnt     <= 5'd0;
      div_rem     <= 32'd0;
      div_quo     <= src1_abs;
      div_dvs     <= src2_abs;
      div_by_zero <= (es_src2 == 32'd0);
    end else if (div_state == DIV_BUSY) begin
      div_cnt <= div_cnt + 5'd1;
      div_rem <= div_rem_nxt;
      div_quo <= div_quo_nxt;
      if (div_last) begin
        div_result <= div_final;
      end
    end
  end

  logic [31:0] es_result;

  assign es_ready_go = is_div ? (div_state == DIV_DONE) : 1'b1;
  assign es_result   = is_div ? div_result : (is_mul ? mul_result : alu_result);

  assign es_to_ms_bus  = {es_res_from_mem, es_rf_we, es_waddr, es_result, es_pc};
  // Gating with es_valid keeps a bubble from forwarding or stalling decode
  assign es_rf_collect = {es_res_from_mem & es_valid, es_rf_we & es_valid, es_waddr, es_result};

  assign data_sram_en    = es_valid & (es_res_from_mem | es_mem_we) & ms_allowin;
  assign data_sram_we    = {4{es_valid & es_mem_we & ms_allowin}};
  assign data_sram_addr  = alu_add;
  assign data_sram_wdata = es_rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU/mul results, divider latency
// and sign rules, SRAM requests, back-pressure hold and mid-divide reset.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ds_to_es_valid;
  logic         es_allowin;
  logic [154:0] ds_to_es_bus;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_rf_collect;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int total = 0;
  int bad   = 0;
  int lat;

  localparam logic [18:0] OP_ADD     = 19'h00001;
  localparam logic [18:0] OP_SUB     = 19'h00002;
  localparam logic [18:0] OP_SLT     = 19'h00004;
  localparam logic [18:0] OP_SLTU    = 19'h00008;
  localparam logic [18:0] OP_SRA     = 19'h00400;
  localparam logic [18:0] OP_LUI     = 19'h00800;
  localparam logic [18:0] OP_MOD_WU  = 19'h01000;
  localparam logic [18:0] OP_DIV_WU  = 19'h02000;
  localparam logic [18:0] OP_MOD_W   = 19'h04000;
  localparam logic [18:0] OP_DIV_W   = 19'h08000;
  localparam logic [18:0] OP_MULH_WU = 19'h10000;
  localparam logic [18:0] OP_MULH_W  = 19'h20000;
  localparam logic [18:0] OP_MUL_W   = 19'h40000;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_to_es_bus    (ds_to_es_bus),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_rf_collect   (es_rf_collect),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [18:0] op, input logic rfm, input logic [31:0] s1,
                               input logic [31:0] s2, input logic mwe, input logic rwe,
                               input logic [4:0] wa, input logic [31:0] rkd, input logic [31:0] pc);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = {op, rfm, s1, s2, mwe, rwe, wa, rkd, pc};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ds_to_es_valid = 1'b0;
  endtask

  // Counts cycles until es_to_ms_valid rises, giving up after 60
  task automatic waitResult(output int cycles);
    cycles = 0;
    while (es_to_ms_valid !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  // Issue one single-cycle op and check the result it presents
  task automatic aluOp(input string tag, input logic [18:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] expected);
    applyStimulus(op, 1'b0, s1, s2, 1'b0, 1'b1, 5'd1, 32'd0, 32'h1c00_0000);
    tick();
    idle();
    checkOutput({tag, "_result"}, es_to_ms_bus[63:32], expected);
  endtask

  // Issue one divide and check both its latency and its result
  task automatic divOp(input string tag, input logic [18:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] expected);
    applyStimulus(op, 1'b0, s1, s2, 1'b0, 1'b1, 5'd2, 32'd0, 32'h1c00_0100);
    tick();
    idle();
    waitResult(lat);
    checkOutput({tag, "_latency"}, lat, 33);
    checkOutput({tag, "_result"}, es_to_ms_bus[63:32], expected);
  endtask

  initial begin
    reset          = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    ms_allowin     = 1'b1;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_allowin", es_allowin, 1);
    checkOutput("rst_ms_valid", es_to_ms_valid, 0);
    checkOutput("rst_ms_bus", es_to_ms_bus, 0);
    checkOutput("rst_collect", es_rf_collect, 0);
    checkOutput("rst_sram", {data_sram_en, data_sram_we, data_sram_addr}, 0);
    reset = 1'b0;

    $display("[TB] add and forwarding");
    applyStimulus(OP_ADD, 1'b0, 32'd5, 32'd7, 1'b0, 1'b1, 5'd3, 32'd0, 32'h1c00_0000);
    tick();
    idle();
    checkOutput("add_valid", es_to_ms_valid, 1);
    checkOutput("add_result", es_to_ms_bus[63:32], 12);
    checkOutput("add_collect", es_rf_collect, {1'b0, 1'b1, 5'd3, 32'd12});
    checkOutput("add_pc", es_to_ms_bus[31:0], 32'h1c00_0000);
    tick();
    checkOutput("bubble_collect_we", es_rf_collect[37], 0);

    $display("[TB] alu and multiply");
    aluOp("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    aluOp("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    aluOp("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    aluOp("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    aluOp("lui", OP_LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
    aluOp("mulh_w", OP_MULH_W, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    aluOp("mulh_wu", OP_MULH_WU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    aluOp("mul_w", OP_MUL_W, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);

    $display("[TB] divide with stall");
    applyStimulus(OP_DIV_W, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 5'd6, 32'd0, 32'h1c00_0200);
    tick();
    idle();
    checkOutput("div_stall_allowin", es_allowin, 0);
    checkOutput("div_stall_rf_we", es_rf_collect[37], 1);
    waitResult(lat);
    checkOutput("div_w_latency", lat, 33);
    checkOutput("div_w_result", es_to_ms_bus[63:32], 32'hFFFF_FFFD);
    checkOutput("div_done_allowin", es_allowin, 1);
    // Next divide enters in the same cycle the previous one leaves DONE
    divOp("mod_w", OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    divOp("div_wu_by0", OP_DIV_WU, 32'd7, 32'd0, 32'hFFFF_FFFF);
    divOp("mod_wu_by0", OP_MOD_WU, 32'd7, 32'd0, 32'd7);
    divOp("div_w_ovf", OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    divOp("mod_w_ovf", OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    tick();

    $display("[TB] divide held in DONE by back-pressure");
    applyStimulus(OP_DIV_WU, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 5'd7, 32'd0, 32'h1c00_0300);
    tick();
    idle();
    ms_allowin = 1'b0;
    waitResult(lat);
    checkOutput("hold_latency", lat, 33);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_valid", es_to_ms_valid, 1);
      checkOutput("hold_result", es_to_ms_bus[63:32], 32'd14);
    end
    ms_allowin = 1'b1;
    #1;
    checkOutput("hold_release_allowin", es_allowin, 1);
    tick();
    checkOutput("hold_released_valid", es_to_ms_valid, 0);

    $display("[TB] store request");
    ms_allowin = 1'b0;
    applyStimulus(OP_ADD, 1'b0, 32'h1000, 32'h10, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h1c00_0400);
    tick();
    checkOutput("st_blocked_en", data_sram_en, 0);
    checkOutput("st_blocked_we", data_sram_we, 0);
    checkOutput("st_blocked_allowin", es_allowin, 0);
    applyStimulus(OP_ADD, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1, 5'd4, 32'd0, 32'h1c00_0404);
    tick();
    checkOutput("st_hold_addr", data_sram_addr, 32'h1010);
    checkOutput("st_hold_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    ms_allowin = 1'b1;
    #1;
    checkOutput("st_en", data_sram_en, 1);
    checkOutput("st_we", data_sram_we, 4'hF);
    checkOutput("st_addr", data_sram_addr, 32'h1010);
    checkOutput("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    tick();
    idle();
    checkOutput("after_st_result", es_to_ms_bus[63:32], 32'd2);
    checkOutput("after_st_en", data_sram_en, 0);
    tick();

    $display("[TB] reset during divide");
    applyStimulus(OP_DIV_W, 1'b0, 32'd100, 32'd3, 1'b0, 1'b1, 5'd8, 32'd0, 32'h1c00_0500);
    tick();
    idle();
    repeat (11) tick();
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", es_to_ms_valid, 0);
    checkOutput("midrst_allowin", es_allowin, 1);
    checkOutput("midrst_collect", es_rf_collect, 0);
    reset = 1'b0;
    applyStimulus(OP_ADD, 1'b0, 32'd3, 32'd4, 1'b0, 1'b1, 5'd9, 32'd0, 32'h1c00_0600);
    tick();
    idle();
    checkOutput("postrst_add_valid", es_to_ms_valid, 1);
    checkOutput("postrst_add_result", es_to_ms_bus[63:32], 32'd7);
    divOp("postrst_div", OP_DIV_W, 32'd100, 32'd3, 32'd33);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
